dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's memory-request interface.
- Accepts the decoded load and store strobes plus address, store data and access size.
- Performs the access after a fixed, parameterised latency. Returns sign- or zero-extended load data with a one-cycle response pulse.
- Drives a stall back to the pipeline while an access is in flight.
- Sits between the execute/memory stage and the local data SRAM array.

Parameters:
- DATA_W, 32: data word width; fixed at 32 for RV32.
- DEPTH, 256: number of 32-bit words in the array; power of two.
- LATENCY, 2: cycles from the accept edge to rsp_valid_o high; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous, active-low reset
- req_valid_i  input  1  request present this cycle
- req_ready_o  output  1  responder can accept a request
- mem_read_i  input  1  load request strobe
- mem_write_i  input  1  store request strobe
- addr_i  input  32  byte address
- wdata_i  input  32  store data, LSB-aligned
- funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid_o  output  1  one-cycle response pulse
- rdata_o  output  32  extended load data; 0 for stores
- stall_o  output  1  pipeline hold request
- err_o  output  1  access error flag, valid with rsp_valid_o

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, counter 0, rsp_valid_o 0, rdata_o 0, err_o 0. Array contents are not reset. req_ready_o = (state == IDLE), so it reads 1 during reset.
- Accept: req_valid_i & req_ready_o & (mem_read_i | mem_write_i). A request with neither strobe is ignored, and state stays IDLE.
- Both strobes high: treated as a store; rdata_o = 0.
- Request capture: addr, wdata, funct3 and op type are registered at the accept edge. Inputs may change afterwards.
- FSM transitions:
  - IDLE -> BUSY on accept when LATENCY > 1; the counter loads LATENCY-1.
  - IDLE -> RESP on accept when LATENCY == 1.
  - BUSY: the counter decrements each cycle; go to RESP on the edge where the counter reaches 1.
  - RESP -> IDLE unconditionally.
- Response timing: rsp_valid_o = 1 exactly LATENCY cycles after the accept edge, for exactly one cycle.
- Handshake: req_ready_o = 0 in BUSY and RESP. The earliest next accept is the cycle after RESP, so back-to-back throughput is one access per LATENCY+1 cycles.
- stall_o = accept-this-cycle | (state == BUSY). stall_o is 0 in RESP so the pipeline advances with the response.
- Word index: addr[$clog2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Store commit: the write is committed on the edge entering RESP, using byte enables:
  - SB: 1 lane selected by addr[1:0].
  - SH: 2 lanes at addr[1]*2.
  - SW: all 4 lanes.
  - Store data is replicated into the selected lanes.
- Load data: the word is read on the same edge and the selected byte/half is shifted down into rdata_o.
  - B/H: sign-extended.
  - BU/HU: zero-extended.
  - W: unchanged.
- Undefined funct3 codes (011, 110, 111): treated as W.
- Read/write ordering: a load that follows a store to the same word returns the new data, because the store commits before the next accept is possible.
- Reset mid-operation: the pending request is dropped and no write occurs if reset asserts before the RESP-entry edge. After reset release the FSM is in IDLE and no response is issued.
- err_o = 0 unless the optional feature below is enabled.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] != 0, is misaligned.
  - A misaligned access still takes LATENCY cycles.
  - In RESP: err_o = 1, rdata_o = 0, and no array write.
- Not defined:
  - err_o is tied 0.
  - Low address bits beyond the access size are ignored: H uses addr[1], W forces the lane to 0.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid_o 2 cycles after each accept; rdata_o 0xDEADBEEF; stall_o high for the accept cycle and BUSY only.
- SB 0x81 at addr 0x13 over word 0x00000000, then LB 0x13 and LBU 0x13 -> LB rdata_o 0xFFFFFF81; LBU rdata_o 0x00000081; word reads 0x81000000.
- SH 0x8001 at addr 0x22, then LH 0x22 and LHU 0x22 -> LH 0xFFFF8001; LHU 0x00008001.
- Wrap: SW 0xA5A5A5A5 at addr 0x400 (DEPTH 256), then LW 0x0 -> 0xA5A5A5A5. During each access, req_ready_o is 0 in BUSY/RESP and a req_valid_i pulse in RESP is not accepted.
- Reset: assert rst_ni low during BUSY of SW 0x55 at 0x30, release -> no rsp_valid_o, state IDLE; a following LW 0x30 returns the prior contents.
- With DMEM_MISALIGN_CHECK_EN defined: LW addr 0x11 -> rsp_valid_o after 2 cycles, err_o 1, rdata_o 0. SW 0x11 -> err_o 1 and the word at 0x10 is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipeline's memory-request port.
// A load or store is accepted in IDLE and completes a fixed LATENCY cycles later.
// The response is a one-cycle rsp_valid_o pulse that carries extended load data.
// stall_o holds the pipeline while the access is in flight.
// Optional build macro: DMEM_MISALIGN_CHECK_EN. When it is defined, misaligned
// halfword and word accesses are flagged on err_o and do not touch the array.
// Handshake: a request is taken on a rising edge where req_valid_i, req_ready_o
// and at least one strobe are high. req_ready_o depends only on registered
// state, so it never combinationally follows req_valid_i.
module dmem_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [2:0]        funct3_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              err_o
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;

    // Request captured at the accept edge
    logic [AW+1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic              store_q;

    // The data array itself is never reset
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              commit;
    logic [AW+1:0]     cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [2:0]        cur_funct3;
    logic              cur_store;
    logic [1:0]        size;
    logic              is_signed;
    logic [AW-1:0]     idx;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [DATA_W-1:0] wrep;
    logic [DATA_W-1:0] word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [DATA_W-1:0] load_data;
    logic              misalign;
    logic              unused_addr_bits;

    // The address bits above the word index are ignored, so addresses wrap
    assign unused_addr_bits = ^addr_i[31:AW+2];

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i & req_ready_o & (mem_read_i | mem_write_i);
    assign stall_o     = accept | (state == BUSY);

    // Select the live request: the raw inputs when LATENCY is 1, otherwise the captured copy
    always_comb begin
        cur_addr   = addr_q;
        cur_wdata  = wdata_q;
        cur_funct3 = funct3_q;
        cur_store  = store_q;
        if (state == IDLE) begin
            cur_addr   = addr_i[AW+1:0];
            cur_wdata  = wdata_i;
            cur_funct3 = funct3_i;
            cur_store  = mem_write_i;
        end
    end

    // This is the edge that completes the access: either a single-cycle accept or the last BUSY cycle
    always_comb begin
        enter_resp = 1'b0;
        if (state == IDLE && accept && LATENCY == 1) begin
            enter_resp = 1'b1;
        end else if (state == BUSY && cnt == 4'd1) begin
            enter_resp = 1'b1;
        end
    end

    // Decode the access size, lane, byte enables and alignment.
    // Undefined funct3 codes fall through to word.
    always_comb begin
        size      = 2'b10;
        is_signed = ~cur_funct3[2];
        idx       = cur_addr[AW+1:2];
        lane      = 2'b00;
        be        = 4'b1111;
        wrep      = cur_wdata;
        case (cur_funct3[1:0])
            2'b00: begin
                size = 2'b00;
                lane = cur_addr[1:0];
                be   = 4'b0001 << cur_addr[1:0];
                wrep = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                size = 2'b01;
                lane = {cur_addr[1], 1'b0};
                be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{cur_wdata[15:0]}};
            end
            default: begin
                size = 2'b10;
            end
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = ((size == 2'b01) && cur_addr[0]) ||
                   ((size == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Pull the addressed byte or half out of the word, then sign- or zero-extend it
    always_comb begin
        word      = mem[idx];
        sel_byte  = word[{lane, 3'b000} +: 8];
        sel_half  = lane[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (size)
            2'b00:   load_data = is_signed ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
            2'b01:   load_data = is_signed ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
            default: load_data = word;
        endcase
    end

    assign commit = enter_resp & cur_store & ~misalign;

    // Commit the store lanes on the edge that enters RESP
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wrep[b*8 +: 8];
                end
            end
        end
    end

    // Run the request FSM and register the response outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= 3'b000;
            store_q     <= 1'b0;
            rsp_valid_o <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= enter_resp;
            err_o       <= enter_resp & misalign;
            rdata_o     <= (enter_resp && !cur_store && !misalign) ? load_data : '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= addr_i[AW+1:0];
                        wdata_q  <= wdata_i;
                        funct3_q <= funct3_i;
                        store_q  <= mem_write_i;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed-vector bench for dmem_responder with LATENCY = 2.
// Every expected value is hand-computed.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(LAT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .funct3_i    (funct3),
        .rsp_valid_o (rsp_valid),
        .rdata_o     (rdata),
        .stall_o     (stall),
        .err_o       (err)
    );

    // Clock and global time limit
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        funct3    = 3'b010;
    endtask

    // Issue one request and follow it through BUSY and RESP.
    // While the access is in flight, a conflicting request is held on the inputs.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input logic [31:0] exp_data, input logic exp_err,
                          input string tag);
        int k;
        @(negedge clk);
        req_valid = 1'b1; mem_write = wr; mem_read = rd; addr = a; wdata = d; funct3 = f3;
        #1;
        check({tag, "_ready_acc"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_stall_acc"}, {31'd0, stall}, 32'd1);
        @(negedge clk);
        req_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0;
        addr = 32'h0000_03FC; wdata = 32'h1357_9BDF; funct3 = 3'b000;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 16) begin
            check({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
            check({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, LAT);
        check({tag, "_ready_resp"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_stall_resp"}, {31'd0, stall}, 32'd0);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        check({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        drive_idle();
        #1;
        check({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
    endtask

    // Main sequence
    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;

        // Basic word store then load
        access(1, 0, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, "sw10");
        access(0, 1, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw10");

        // Byte store into a cleared word, then signed and unsigned byte loads
        access(1, 0, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0, "sw10_clr");
        access(1, 0, 32'h13, 32'h1234_5681, 3'b000, 32'h0, 1'b0, "sb13");
        access(0, 1, 32'h13, 32'h0, 3'b000, 32'hFFFF_FF81, 1'b0, "lb13");
        access(0, 1, 32'h13, 32'h0, 3'b100, 32'h0000_0081, 1'b0, "lbu13");
        access(0, 1, 32'h10, 32'h0, 3'b010, 32'h8100_0000, 1'b0, "lw10_b");

        // Halfword store into the upper half, then half and byte loads
        access(1, 0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0, "sw20_clr");
        access(1, 0, 32'h22, 32'hABCD_8001, 3'b001, 32'h0, 1'b0, "sh22");
        access(0, 1, 32'h22, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0, "lh22");
        access(0, 1, 32'h22, 32'h0, 3'b101, 32'h0000_8001, 1'b0, "lhu22");
        access(0, 1, 32'h20, 32'h0, 3'b010, 32'h8001_0000, 1'b0, "lw20_h");
        access(0, 1, 32'h23, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0, "lb23");
        access(0, 1, 32'h22, 32'h0, 3'b100, 32'h0000_0001, 1'b0, "lbu22");

        // Address wrap and an undefined funct3 code that reads as a word
        access(1, 0, 32'h400, 32'hA5A5_A5A5, 3'b010, 32'h0, 1'b0, "sw400");
        access(0, 1, 32'h0, 32'h0, 3'b010, 32'hA5A5_A5A5, 1'b0, "lw0_wrap");
        access(0, 1, 32'h0, 32'h0, 3'b011, 32'hA5A5_A5A5, 1'b0, "ld011");

        // Both strobes high behaves as a store
        access(1, 1, 32'h40, 32'h0F0F_0F0F, 3'b010, 32'h0, 1'b0, "both40");
        access(0, 1, 32'h40, 32'h0, 3'b010, 32'h0F0F_0F0F, 1'b0, "lw40");

        // A request with neither strobe is ignored
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h40;
        #1;
        check("nostrobe_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        check("nostrobe_ready", {31'd0, req_ready}, 32'd1);
        check("nostrobe_rsp", {31'd0, rsp_valid}, 32'd0);
        drive_idle();

        // Reset during BUSY drops the store
        access(1, 0, 32'h30, 32'h1111_2222, 3'b010, 32'h0, 1'b0, "sw30_prior");
        @(negedge clk);
        req_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; addr = 32'h30; wdata = 32'h55; funct3 = 3'b010;
        @(negedge clk);
        drive_idle();
        check("midrst_busy_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_rsp", {31'd0, rsp_valid}, 32'd0);
            check("postrst_ready", {31'd0, req_ready}, 32'd1);
        end
        access(0, 1, 32'h30, 32'h0, 3'b010, 32'h1111_2222, 1'b0, "lw30_after_rst");

        // Misaligned accesses
        access(1, 0, 32'h10, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0, "sw10_cafe");
`ifdef DMEM_MISALIGN_CHECK_EN
        access(0, 1, 32'h11, 32'h0, 3'b010, 32'h0, 1'b1, "lw11_mis");
        access(0, 1, 32'h13, 32'h0, 3'b001, 32'h0, 1'b1, "lh13_mis");
        access(1, 0, 32'h11, 32'h0BAD_BEEF, 3'b010, 32'h0, 1'b1, "sw11_mis");
        access(0, 1, 32'h10, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0, "lw10_kept");
`else
        access(0, 1, 32'h11, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0, "lw11_lane0");
        access(0, 1, 32'h13, 32'h0, 3'b001, 32'hFFFF_CAFE, 1'b0, "lh13_upper");
        access(1, 0, 32'h11, 32'h0BAD_BEEF, 3'b010, 32'h0, 1'b0, "sw11_word");
        access(0, 1, 32'h10, 32'h0, 3'b010, 32'h0BAD_BEEF, 1'b0, "lw10_new");
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
